// File: rtl/alu_issue_scheduler_pkg.sv
// Shared types for the ALU issue scheduler: op encoding, source tag and the
// per-stage entry that tracks an operation through the ALU pipeline.
package alu_sched_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } alu_op_t;

  typedef logic src_t;

  typedef struct packed {
    logic valid;
    src_t src;
  } sched_entry_t;

  localparam src_t SRC_REQ0 = 1'b0;
  localparam src_t SRC_REQ1 = 1'b1;

  // Round-robin choice: contention goes to rr, otherwise whoever is asking.
  function automatic src_t rr_pick(logic v0, logic v1, src_t rr);
    if (v0 && v1) begin
      return rr;
    end
    return v1 ? SRC_REQ1 : SRC_REQ0;
  endfunction

endpackage

// File: rtl/alu_issue_scheduler_if.sv
// Bundles for the scheduler: requester handshake, ALU drive/return path and
// the response stream.
interface alu_req_if #(
  parameter int WIDTH = 32
);
  import alu_sched_pkg::*;

  logic             valid;
  logic             ready;
  alu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  modport master (output valid, op, a, b, input ready);
  modport slave  (input valid, op, a, b, output ready);
endinterface

interface alu_port_if #(
  parameter int WIDTH = 32
);
  import alu_sched_pkg::*;

  alu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;

  modport master (output op, a, b, input result);
  modport slave  (input op, a, b, output result);
endinterface

interface alu_resp_if #(
  parameter int WIDTH = 32
);
  import alu_sched_pkg::*;

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  src_t             src;

  modport master (output valid, data, src, input ready);
  modport slave  (input valid, data, src, output ready);
endinterface

// File: rtl/alu_issue_scheduler_resp_fifo.sv
// First-word-fall-through response FIFO; head reads as zero while empty so the
// response bus is quiet out of reset.
module resp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] bump(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rd];
  assign o_count = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= bump(r_wr);
      end
      if (w_pop) begin
        r_rd <= bump(r_rd);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // Upstream credit accounting must never let a push meet a full FIFO.
  overflow_a: assert property (@(posedge clk) disable iff (!reset)
                               !(i_push && w_full && !i_pop));

endmodule

// File: rtl/alu_issue_scheduler.sv
// Shares one fixed-latency FP ALU between two requesters: round-robin issue,
// source tracking through a shift pipeline, credit-limited response FIFO.
module alu_issue_scheduler
  import alu_sched_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int LAT        = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  alu_req_if.slave   i_req0,
  alu_req_if.slave   i_req1,
  alu_port_if.master o_alu,
  alu_resp_if.master o_resp,
  input  logic       i_drain,
  output logic       o_idle
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(LAT + 1);
  localparam int OW = ((CW > IW) ? CW : IW) + 1;

  src_t             r_rr;
  logic             r_started;
  logic [IW-1:0]    r_inflight;
  sched_entry_t     r_pipe [LAT];

  logic             w_anyValid;
  src_t             w_grant;
  logic [OW-1:0]    w_occ;
  logic             w_canIssue;
  logic             w_issue;
  logic             w_fifoPush;
  logic             w_fifoPop;
  logic             w_fifoEmpty;
  logic [CW-1:0]    w_fifoCount;
  logic [WIDTH:0]   w_fifoHead;

  // Credits count every op already committed to a FIFO slot; a pop in the
  // current cycle is deliberately not credited until it is registered.
  assign w_anyValid = i_req0.valid || i_req1.valid;
  assign w_grant    = rr_pick(i_req0.valid, i_req1.valid, r_rr);
  assign w_occ      = OW'(r_inflight) + OW'(w_fifoCount);
  assign w_canIssue = r_started && !i_drain && (w_occ < OW'(FIFO_DEPTH));
  assign w_issue    = w_canIssue && w_anyValid;

  assign i_req0.ready = w_issue && (w_grant == SRC_REQ0);
  assign i_req1.ready = w_issue && (w_grant == SRC_REQ1);

  always_comb begin
    o_alu.op = OP_ADD;
    o_alu.a  = '0;
    o_alu.b  = '0;
    if (w_issue) begin
      if (w_grant == SRC_REQ1) begin
        o_alu.op = i_req1.op;
        o_alu.a  = i_req1.a;
        o_alu.b  = i_req1.b;
      end else begin
        o_alu.op = i_req0.op;
        o_alu.a  = i_req0.a;
        o_alu.b  = i_req0.b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr       <= SRC_REQ0;
      r_started  <= 1'b0;
      r_inflight <= '0;
    end else begin
      r_started <= 1'b1;
      if (w_issue) begin
        r_rr <= ~w_grant;
      end
      case ({w_issue, w_fifoPush})
        2'b10:   r_inflight <= r_inflight + IW'(1);
        2'b01:   r_inflight <= r_inflight - IW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // One entry per ALU stage; the last stage lines up with alu_result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0].valid <= w_issue;
      r_pipe[0].src   <= w_issue ? w_grant : SRC_REQ0;
      for (int i = 1; i < LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign w_fifoPush = r_pipe[LAT-1].valid;
  assign w_fifoPop  = !w_fifoEmpty && o_resp.ready;

  resp_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_fifoPush),
    .i_data  ({r_pipe[LAT-1].src, o_alu.result}),
    .i_pop   (w_fifoPop),
    .o_data  (w_fifoHead),
    .o_empty (w_fifoEmpty),
    .o_count (w_fifoCount)
  );

  assign o_resp.valid = !w_fifoEmpty;
  assign o_resp.data  = w_fifoHead[WIDTH-1:0];
  assign o_resp.src   = w_fifoHead[WIDTH];
  assign o_idle       = (r_inflight == '0) && w_fifoEmpty;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Testbench for alu_issue_scheduler: two instances (LAT=1/DEPTH=4 and
// LAT=3/DEPTH=5) with scoreboarded responses from a small ALU model.
module tb_alu_issue_scheduler;
  import alu_sched_pkg::*;

  logic clk;
  logic reset;
  logic drainA;
  logic drainB;
  logic idleA;
  logic idleB;

  alu_req_if  #(.WIDTH(32)) reqA0 ();
  alu_req_if  #(.WIDTH(32)) reqA1 ();
  alu_port_if #(.WIDTH(32)) aluA ();
  alu_resp_if #(.WIDTH(32)) respA ();
  alu_req_if  #(.WIDTH(32)) reqB0 ();
  alu_req_if  #(.WIDTH(32)) reqB1 ();
  alu_port_if #(.WIDTH(32)) aluB ();
  alu_resp_if #(.WIDTH(32)) respB ();

  alu_issue_scheduler #(.WIDTH(32), .LAT(1), .FIFO_DEPTH(4)) u_dutA (
    .clk(clk), .reset(reset), .i_req0(reqA0), .i_req1(reqA1),
    .o_alu(aluA), .o_resp(respA), .i_drain(drainA), .o_idle(idleA));

  alu_issue_scheduler #(.WIDTH(32), .LAT(3), .FIFO_DEPTH(5)) u_dutB (
    .clk(clk), .reset(reset), .i_req0(reqB0), .i_req1(reqB1),
    .o_alu(aluB), .o_resp(respB), .i_drain(drainB), .o_idle(idleB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: exact IEEE results for the operand pairs in the plan,
  // distinct deterministic values for everything else.
  function automatic logic [31:0] fakeAlu(alu_op_t op, logic [31:0] a, logic [31:0] b);
    if (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == OP_MUL && a == 32'h3FC00000 && b == 32'h40000000) return 32'h40400000;
    if (op == OP_ADD && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    return (op == OP_MUL) ? (a ^ {b[15:0], b[31:16]}) : (a + b);
  endfunction

  logic [31:0] aluAr;
  logic [31:0] aluB1;
  logic [31:0] aluB2;
  logic [31:0] aluB3;

  always @(posedge clk) begin
    aluAr <= fakeAlu(aluA.op, aluA.a, aluA.b);
    aluB1 <= fakeAlu(aluB.op, aluB.a, aluB.b);
    aluB2 <= aluB1;
    aluB3 <= aluB2;
  end

  assign aluA.result = aluAr;
  assign aluB.result = aluB3;

  int assertCount = 0;
  int failCount   = 0;
  int cycA = 0;
  int cycB = 0;
  logic [32:0] sbA[$];
  logic [32:0] sbB[$];
  logic accA0, accA1, rdyA0, popA, idleSampA;
  logic accB0, accB1, popB;
  logic [31:0] popDataA;
  logic        popSrcA;

  task automatic idleInputs();
    reqA0.valid = 0; reqA0.op = OP_ADD; reqA0.a = '0; reqA0.b = '0;
    reqA1.valid = 0; reqA1.op = OP_ADD; reqA1.a = '0; reqA1.b = '0;
    reqB0.valid = 0; reqB0.op = OP_ADD; reqB0.a = '0; reqB0.b = '0;
    reqB1.valid = 0; reqB1.op = OP_ADD; reqB1.a = '0; reqB1.b = '0;
    respA.ready = 0; respB.ready = 0; drainA = 0; drainB = 0;
  endtask

  // Called just after a falling edge with inputs set: records accepts and
  // pops for the coming rising edge, then returns at the next falling edge.
  task automatic tickA();
    logic [32:0] exp;
    #1;
    rdyA0     = reqA0.ready;
    accA0     = reqA0.valid && reqA0.ready;
    accA1     = reqA1.valid && reqA1.ready;
    popA      = respA.valid && respA.ready;
    popDataA  = respA.data;
    popSrcA   = respA.src;
    idleSampA = idleA;
    if (accA0) sbA.push_back({1'b0, fakeAlu(reqA0.op, reqA0.a, reqA0.b)});
    if (accA1) sbA.push_back({1'b1, fakeAlu(reqA1.op, reqA1.a, reqA1.b)});
    if (popA) begin
      assertCount++;
      if (sbA.size() == 0) begin
        failCount++;
        $display("[TB] FAIL respA_unexpected: got src=%0d data=%h, expected no response", respA.src, respA.data);
      end else begin
        exp = sbA.pop_front();
        if ({respA.src, respA.data} !== exp) begin
          failCount++;
          $display("[TB] FAIL respA_data: got src=%0d data=%h, expected src=%0d data=%h", respA.src, respA.data, exp[32], exp[31:0]);
        end
      end
    end
    cycA++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tickB();
    logic [32:0] exp;
    #1;
    accB0 = reqB0.valid && reqB0.ready;
    accB1 = reqB1.valid && reqB1.ready;
    popB  = respB.valid && respB.ready;
    if (accB0) sbB.push_back({1'b0, fakeAlu(reqB0.op, reqB0.a, reqB0.b)});
    if (accB1) sbB.push_back({1'b1, fakeAlu(reqB1.op, reqB1.a, reqB1.b)});
    if (popB) begin
      assertCount++;
      if (sbB.size() == 0) begin
        failCount++;
        $display("[TB] FAIL respB_unexpected: got src=%0d data=%h, expected no response", respB.src, respB.data);
      end else begin
        exp = sbB.pop_front();
        if ({respB.src, respB.data} !== exp) begin
          failCount++;
          $display("[TB] FAIL respB_data: got src=%0d data=%h, expected src=%0d data=%h", respB.src, respB.data, exp[32], exp[31:0]);
        end
      end
    end
    cycB++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    idleInputs();
    reset = 0;
    @(negedge clk);
    reset = 1;
    sbA.delete();
    sbB.delete();
    @(negedge clk);
  endtask

  task automatic flushA(output bit ok);
    reqA0.valid = 0; reqA1.valid = 0; drainA = 0; respA.ready = 1;
    for (int i = 0; i < 20; i++) begin
      if (sbA.size() == 0 && idleA) break;
      tickA();
    end
    ok = (sbA.size() == 0) && idleA;
  endtask

  task automatic flushB(output bit ok);
    reqB0.valid = 0; reqB1.valid = 0; drainB = 0; respB.ready = 1;
    for (int i = 0; i < 30; i++) begin
      if (sbB.size() == 0 && idleB) break;
      tickB();
    end
    ok = (sbB.size() == 0) && idleB;
  endtask

  task automatic test_reset();
    idleInputs();
    reset = 1;
    #1 reset = 0;
    reqA0.valid = 1; reqA0.a = 32'h3F800000; reqA0.b = 32'h40000000;
    reqA1.valid = 1; reqA1.op = OP_MUL; reqA1.a = 32'h12345678;
    @(negedge clk);
    #1;
    assertCount++; if (reqA0.ready !== 1'b0) begin failCount++; $display("[TB] FAIL rst_ready0: got %b, expected 0", reqA0.ready); end
    assertCount++; if (reqA1.ready !== 1'b0) begin failCount++; $display("[TB] FAIL rst_ready1: got %b, expected 0", reqA1.ready); end
    assertCount++; if (aluA.a !== 32'h0 || aluA.b !== 32'h0 || aluA.op !== OP_ADD) begin failCount++; $display("[TB] FAIL rst_alu: got op=%b a=%h b=%h, expected all 0", aluA.op, aluA.a, aluA.b); end
    assertCount++; if (respA.valid !== 1'b0 || respA.data !== 32'h0 || respA.src !== 1'b0) begin failCount++; $display("[TB] FAIL rst_resp: got v=%b d=%h s=%b, expected 0/0/0", respA.valid, respA.data, respA.src); end
    assertCount++; if (idleA !== 1'b1 || idleB !== 1'b1) begin failCount++; $display("[TB] FAIL rst_idle: got A=%b B=%b, expected 1/1", idleA, idleB); end
    assertCount++; if (respB.valid !== 1'b0) begin failCount++; $display("[TB] FAIL rst_respB: got %b, expected 0", respB.valid); end
    reset = 1;
    #1;
    assertCount++; if (reqA0.ready !== 1'b0) begin failCount++; $display("[TB] FAIL ready_before_first_clock: got %b, expected 0", reqA0.ready); end
    reqA0.valid = 0; reqA1.valid = 0;
    @(posedge clk);
    @(negedge clk);
    reqA0.valid = 1;
    #1;
    assertCount++; if (reqA0.ready !== 1'b1) begin failCount++; $display("[TB] FAIL ready_after_first_clock: got %b, expected 1", reqA0.ready); end
    reqA0.valid = 0;
  endtask

  task automatic test_single();
    int acceptCyc;
    int popCyc;
    bit ok;
    doReset();
    respA.ready = 1;
    reqA0.valid = 1; reqA0.op = OP_ADD; reqA0.a = 32'h3F800000; reqA0.b = 32'h40000000;
    acceptCyc = cycA;
    tickA();
    assertCount++; if (accA0 !== 1'b1) begin failCount++; $display("[TB] FAIL single_accept: got %b, expected 1", accA0); end
    reqA0.valid = 0;
    popCyc = -1;
    for (int i = 0; i < 8; i++) begin
      int cur;
      cur = cycA;
      tickA();
      if (i == 0) begin
        assertCount++; if (idleSampA !== 1'b0) begin failCount++; $display("[TB] FAIL single_busy: got idle=%b, expected 0", idleSampA); end
      end
      if (popA) begin
        popCyc = cur;
        break;
      end
    end
    assertCount++; if (popCyc - acceptCyc != 2) begin failCount++; $display("[TB] FAIL single_latency: got %0d cycles, expected 2", popCyc - acceptCyc); end
    assertCount++; if (popDataA !== 32'h40400000 || popSrcA !== 1'b0) begin failCount++; $display("[TB] FAIL single_result: got d=%h s=%b, expected 40400000/0", popDataA, popSrcA); end
    tickA();
    assertCount++; if (idleSampA !== 1'b1) begin failCount++; $display("[TB] FAIL single_idle: got %b, expected 1", idleSampA); end
    flushA(ok);
  endtask

  task automatic test_alternate();
    bit ok;
    doReset();
    respA.ready = 1;
    reqA0.valid = 1; reqA0.op = OP_MUL; reqA0.a = 32'h3FC00000; reqA0.b = 32'h40000000;
    reqA1.valid = 1; reqA1.op = OP_ADD; reqA1.a = 32'h3F800000; reqA1.b = 32'h3F800000;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] expAcc;
      tickA();
      expAcc = (i % 2 == 0) ? 2'b10 : 2'b01;
      assertCount++;
      if ({accA0, accA1} !== expAcc) begin failCount++; $display("[TB] FAIL alt_grant[%0d]: got %b, expected %b", i, {accA0, accA1}, expAcc); end
    end
    flushA(ok);
    assertCount++; if (ok !== 1'b1) begin failCount++; $display("[TB] FAIL alt_flush: got %0d outstanding, expected 0", sbA.size()); end
  endtask

  task automatic test_backpressure();
    int accCount;
    bit ok;
    doReset();
    respA.ready = 0;
    accCount = 0;
    for (int i = 0; i < 10; i++) begin
      reqA0.valid = 1; reqA0.op = OP_ADD; reqA0.a = 32'h100 + i; reqA0.b = 32'h7;
      tickA();
      if (accA0) accCount++;
    end
    assertCount++; if (accCount != 4) begin failCount++; $display("[TB] FAIL bp_accepts: got %0d, expected 4", accCount); end
    assertCount++; if (rdyA0 !== 1'b0) begin failCount++; $display("[TB] FAIL bp_ready_low: got %b, expected 0", rdyA0); end
    respA.ready = 1;
    reqA0.a = 32'h200;
    tickA();
    assertCount++; if (popA !== 1'b1 || accA0 !== 1'b0) begin failCount++; $display("[TB] FAIL bp_first_pop: got pop=%b acc=%b, expected 1/0", popA, accA0); end
    reqA0.a = 32'h201;
    tickA();
    assertCount++; if (accA0 !== 1'b1) begin failCount++; $display("[TB] FAIL bp_resume: got %b, expected 1", accA0); end
    for (int i = 0; i < 6; i++) begin
      reqA0.a = 32'h300 + i;
      tickA();
    end
    flushA(ok);
    assertCount++; if (ok !== 1'b1) begin failCount++; $display("[TB] FAIL bp_flush: got %0d outstanding, expected 0", sbA.size()); end
  endtask

  task automatic test_drain();
    int accCount;
    bit readySeen;
    bit ok;
    doReset();
    respA.ready = 1;
    accCount = 0;
    for (int i = 0; i < 2; i++) begin
      reqA0.valid = 1; reqA0.op = OP_MUL; reqA0.a = 32'h40 + i; reqA0.b = 32'h12345678;
      tickA();
      if (accA0) accCount++;
    end
    assertCount++; if (accCount != 2) begin failCount++; $display("[TB] FAIL drain_setup: got %0d accepts, expected 2", accCount); end
    drainA = 1;
    readySeen = 0;
    for (int i = 0; i < 5; i++) begin
      reqA0.a = 32'h50 + i;
      tickA();
      if (rdyA0) readySeen = 1;
    end
    assertCount++; if (readySeen !== 1'b0) begin failCount++; $display("[TB] FAIL drain_ready: got ready seen=%b, expected 0", readySeen); end
    assertCount++; if (sbA.size() != 0) begin failCount++; $display("[TB] FAIL drain_delivered: got %0d outstanding, expected 0", sbA.size()); end
    assertCount++; if (idleA !== 1'b1) begin failCount++; $display("[TB] FAIL drain_idle: got %b, expected 1", idleA); end
    drainA = 0;
    tickA();
    assertCount++; if (accA0 !== 1'b1) begin failCount++; $display("[TB] FAIL drain_resume: got %b, expected 1", accA0); end
    flushA(ok);
    assertCount++; if (ok !== 1'b1) begin failCount++; $display("[TB] FAIL drain_flush: got %0d outstanding, expected 0", sbA.size()); end
  endtask

  task automatic test_back_to_back();
    int gaps;
    int altErr;
    bit ok;
    doReset();
    respB.ready = 1;
    gaps = 0;
    altErr = 0;
    reqB0.valid = 1; reqB1.valid = 1;
    for (int i = 0; i < 20; i++) begin
      reqB0.op = OP_ADD; reqB0.a = 32'h1000 + i; reqB0.b = 32'h5;
      reqB1.op = OP_MUL; reqB1.a = 32'h2000 + i; reqB1.b = 32'h00010003;
      tickB();
      if ((accB0 ^ accB1) !== 1'b1) gaps++;
      if (accB0 !== (i % 2 == 0)) altErr++;
    end
    assertCount++; if (gaps != 0) begin failCount++; $display("[TB] FAIL b2b_gaps: got %0d cycles without exactly one grant, expected 0", gaps); end
    assertCount++; if (altErr != 0) begin failCount++; $display("[TB] FAIL b2b_order: got %0d grant-order errors, expected 0", altErr); end
    flushB(ok);
    assertCount++; if (ok !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_flush: got %0d outstanding, expected 0", sbB.size()); end
  endtask

  task automatic test_reset_mid();
    int accCount;
    bit stale;
    bit ok;
    doReset();
    respB.ready = 0;
    accCount = 0;
    for (int i = 0; i < 3; i++) begin
      reqB0.valid = 1; reqB0.op = OP_ADD; reqB0.a = 32'h50 + i; reqB0.b = 32'h1;
      tickB();
      if (accB0) accCount++;
    end
    reqB0.valid = 0;
    tickB();
    assertCount++; if (accCount != 3) begin failCount++; $display("[TB] FAIL mid_setup: got %0d accepts, expected 3", accCount); end
    assertCount++; if (respB.valid !== 1'b1 || idleB !== 1'b0) begin failCount++; $display("[TB] FAIL mid_pre: got v=%b idle=%b, expected 1/0", respB.valid, idleB); end
    #2 reset = 0;
    #1;
    assertCount++; if (respB.valid !== 1'b0 || respB.data !== 32'h0) begin failCount++; $display("[TB] FAIL mid_async_clear: got v=%b d=%h, expected 0/0", respB.valid, respB.data); end
    assertCount++; if (idleB !== 1'b1) begin failCount++; $display("[TB] FAIL mid_idle: got %b, expected 1", idleB); end
    sbB.delete();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    respB.ready = 1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      tickB();
      if (popB) stale = 1;
    end
    assertCount++; if (stale !== 1'b0) begin failCount++; $display("[TB] FAIL mid_stale: got stale response=%b, expected 0", stale); end
    reqB0.valid = 1; reqB0.a = 32'h77;
    reqB1.valid = 1; reqB1.a = 32'h88;
    tickB();
    assertCount++; if ({accB0, accB1} !== 2'b10) begin failCount++; $display("[TB] FAIL mid_first_grant: got %b, expected 10", {accB0, accB1}); end
    flushB(ok);
    assertCount++; if (ok !== 1'b1) begin failCount++; $display("[TB] FAIL mid_flush: got %0d outstanding, expected 0", sbB.size()); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_drain();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_issue_scheduler.md
# alu_issue_scheduler

Shares one static-latency floating-point ALU (add/mul, fixed pipeline depth `LAT`) between two requesters. Round-robin arbitration picks one operation per cycle, tagged with its source. A valid/source shift pipeline tracks each operation through the ALU. Results land in a response FIFO with a valid/ready output, and a credit rule keeps that FIFO from overflowing.

## Interface
- `WIDTH`, 32, operand/result width (IEEE 754 single).
- `LAT`, 1, ALU latency in cycles (max of add/mul stages, already balanced in the ALU); must be ≥1.
- `FIFO_DEPTH`, 4, response FIFO entries; must be ≥1.

- `clk` in 1, sole clock.
- `reset` in 1, asynchronous, active-low.
- `req0_valid` / `req1_valid` in 1, requester offers an op.
- `req0_ready` / `req1_ready` out 1, op accepted this cycle when valid&ready.
- `req0_op` / `req1_op` in 1, 0=add, 1=mul.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in WIDTH, operands.
- `drain` in 1, blocks new issues while high.
- `alu_op` out 1, `alu_a` / `alu_b` out WIDTH, drive the ALU.
- `alu_result` in WIDTH, ALU output, valid LAT cycles after issue.
- `resp_valid` out 1, `resp_ready` in 1, response handshake.
- `resp_data` out WIDTH, result.
- `resp_src` out 1, requester that issued it.
- `idle` out 1, nothing in flight and FIFO empty.

## Operation
- Occupancy = in-flight count + FIFO count, both registered. `can_issue` = !drain && occupancy < FIFO_DEPTH. Same-cycle pop is not credited (conservative).
- Round-robin pointer `rr`, reset to 0.
  - Both valid: grant `rr`.
  - One valid: grant it.
  - After any grant, `rr` ← !granted.
  - `reqN_ready` = can_issue && grant==N (combinational from valids).
- Issue cycle: `alu_op/a/b` = granted request's fields.
  - No issue: `alu_op`=0, `alu_a`=`alu_b`=0.
  - Shift pipeline (depth LAT) entry = {valid=1, src}. Non-issue cycles shift in {0,x}.
- Pipeline output valid: push {alu_result, src} into FIFO. The credit rule guarantees space; overflow is a bug, flagged by an assertion.
- FIFO is first-word-fall-through: `resp_valid` = !empty, `resp_data`/`resp_src` = head. Pop on resp_valid && resp_ready. Push and pop in the same cycle are both honoured.
- `drain` high: in-flight ops still complete and responses still drain. `idle` rises once everything has emptied.
- Reset asserted (any time): pipeline valids cleared, FIFO emptied, `rr`=0, in-flight count 0. Results of in-flight ops are discarded.
- Reset values of outputs:
  - `req*_ready` = 0 until the first clock after deassert, then per the rule above.
  - `alu_*` = 0.
  - `resp_valid` = 0, `resp_data` = 0, `resp_src` = 0.
  - `idle` = 1.

## Timing
- Issue at edge t → ALU result sampled at edge t+LAT → FIFO push. `resp_valid` is visible in cycle t+LAT (after that edge). Minimum request-to-response latency is LAT+1 cycles.
- Sustained one op/cycle requires FIFO_DEPTH ≥ LAT+2 with `resp_ready` held high. Smaller depths throttle `ready`.
- `resp_ready` low: occupancy saturates at FIFO_DEPTH and both readies drop. Issue resumes the cycle after the first pop is registered.
- Responses return in issue order. Source interleaving matches grant order.

## Structure
- Shared package `alu_sched_pkg`:
  - `alu_op_t` enum (OP_ADD=1'b0, OP_MUL=1'b1).
  - `src_t` (1 bit).
  - `sched_entry_t` struct {valid, src}.
- Sub-module `resp_fifo`: parameterised WIDTH+1 data, FIFO_DEPTH, first-word-fall-through, count output.
- Arbiter, credit counter and shift pipeline stay in the top module.

## Test plan
- LAT=1, DEPTH=4. req0 add 0x3F800000+0x40000000, resp_ready=1 → resp_data 0x40400000, resp_src 0, exactly 2 cycles after acceptance; `idle` back to 1 afterwards.
- Both requesters valid continuously: req0 mul 0x3FC00000×0x40000000, req1 add 0x3F800000+0x3F800000 → grants alternate 0,1,0,1 starting with 0. Responses alternate 0x40400000 / 0x40000000 with matching `resp_src`.
- resp_ready=0, req0 streaming → exactly 4 accepts, then req0_ready=0. Raise resp_ready: 4 in-order responses, then accepts resume.
- LAT=3, DEPTH=5, resp_ready=1, both streaming → one grant per cycle, no gaps, no FIFO overflow assertion.
- `drain`=1 with 2 ops in flight → no new ready, both responses delivered, then idle=1. Deassert drain → issue resumes.
- Reset pulsed low with 2 in flight and 1 queued → resp_valid=0 immediately (asynchronous). No stale response after release; first grant goes to req0.
